// File: rtl/translater_rr.sv
// translater_rr: multi-lane FIFO funnel.
// CHANNELS = 2**CH_BITS input lanes each feed a DEPTH = 2**DEPTH_BITS word
// FIFO. At most one lane is popped per cycle, either the lane named by
// `selector` (mode=0) or round-robin starting after the last grant
// (mode=1). The popped word appears on the registered output one edge later.
//
// Ports:
//   clk, reset_L          clock, async active-low reset
//   ENB                   pop enable (pushes continue while low)
//   mode, selector        0 = fixed lane `selector`, 1 = round-robin
//   in_data, in_valid     per-lane push data/strobe, lane i at [i*WIDTH +: WIDTH]
//   ovf_clr               clears sticky overflow flags
//   data_out, valid_out,  registered popped word, its valid, its source lane
//   ch_out
//   full, empty           per-lane FIFO status (combinational from counts)
//   overflow              sticky per-lane drop flag
//
// Optional feature: define TRANSLATER_OVF_EN to enable overflow tracking;
// otherwise overflow is tied to zero and ovf_clr is ignored.

module translater_rr_lane #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 2 ** DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (DEPTH_BITS+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module translater_rr #(
  parameter int WIDTH      = 8,
  parameter int CH_BITS    = 2,
  parameter int DEPTH_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        ENB,
  input  logic                        mode,
  input  logic [CH_BITS-1:0]          selector,
  input  logic [(2**CH_BITS)*WIDTH-1:0] in_data,
  input  logic [2**CH_BITS-1:0]       in_valid,
  input  logic                        ovf_clr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        valid_out,
  output logic [CH_BITS-1:0]          ch_out,
  output logic [2**CH_BITS-1:0]       full,
  output logic [2**CH_BITS-1:0]       empty,
  output logic [2**CH_BITS-1:0]       overflow
);
  localparam int CHANNELS = 2 ** CH_BITS;

  logic [CHANNELS-1:0][WIDTH-1:0] lane_rdata;
  logic [CHANNELS-1:0]            pop_vec, push_ok;
  logic                           gnt_vld;
  logic [CH_BITS-1:0]             gnt_ch, idx;
  logic [CH_BITS-1:0]             last_grant_q;
  logic [WIDTH-1:0]               data_out_q;
  logic                           valid_out_q;
  logic [CH_BITS-1:0]             ch_out_q;

  // A full lane may still accept a push when it is popped the same cycle.
  assign push_ok = in_valid & (~full | pop_vec);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    translater_rr_lane #(.WIDTH(WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .push_i  (push_ok[i]),
      .pop_i   (pop_vec[i]),
      .wdata_i (in_data[i*WIDTH +: WIDTH]),
      .rdata_o (lane_rdata[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Grant uses pre-push empty flags, so a word pushed this cycle cannot be
  // popped until the next one. Round-robin scans last_grant+1 .. last_grant;
  // the CH_BITS-wide sum wraps modulo CHANNELS on its own.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    pop_vec = '0;
    if (ENB) begin
      if (!mode) begin
        if (!empty[selector]) begin
          gnt_vld = 1'b1;
          gnt_ch  = selector;
        end
      end else begin
        for (int k = 1; k <= CHANNELS; k++) begin
          idx = last_grant_q + CH_BITS'(k);
          if (!gnt_vld && !empty[idx]) begin
            gnt_vld = 1'b1;
            gnt_ch  = idx;
          end
        end
      end
    end
    if (gnt_vld) pop_vec[gnt_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_grant_q <= CH_BITS'(CHANNELS - 1);
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      ch_out_q     <= '0;
    end else begin
      valid_out_q <= gnt_vld;
      if (gnt_vld) begin
        data_out_q <= lane_rdata[gnt_ch];
        ch_out_q   <= gnt_ch;
        if (mode) last_grant_q <= gnt_ch;
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign ch_out    = ch_out_q;

`ifdef TRANSLATER_OVF_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  // A drop in the same cycle as ovf_clr wins: the flag stays set.
  always_comb begin
    ovf_d = ovf_clr ? '0 : ovf_q;
    ovf_d = ovf_d | (in_valid & ~push_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = '0;
`endif
endmodule

// File: doc/translater_rr.md
TRANSLATER_RR -- requirements
Module: translater_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, lane data width in bits.
REQ-002 SHALL have parameter CH_BITS, default 2, giving CHANNELS = 2**CH_BITS input lanes.
REQ-003 SHALL have parameter DEPTH_BITS, default 2, giving per-lane FIFO depth DEPTH = 2**DEPTH_BITS.
REQ-004 SHALL have ports, clock and reset first:
- clk, in, 1, single clock; all state on rising edge.
- reset_L, in, 1, asynchronous active-low reset.
- ENB, in, 1, pop/output enable.
- mode, in, 1: 0 = fixed select, 1 = round-robin.
- selector, in, CH_BITS, lane to pop in fixed mode.
- in_data, in, CHANNELS*WIDTH; lane i occupies bits [i*WIDTH +: WIDTH].
- in_valid, in, CHANNELS, per-lane push strobe.
- ovf_clr, in, 1, clears all overflow flags.
- data_out, out, WIDTH, registered output word.
- valid_out, out, 1, data_out valid this cycle.
- ch_out, out, CH_BITS, source lane of data_out.
- full, out, CHANNELS, per-lane FIFO full.
- empty, out, CHANNELS, per-lane FIFO empty.
- overflow, out, CHANNELS, sticky per-lane drop flag.

Function
REQ-005 SHALL keep one DEPTH-entry FIFO per lane, with count width DEPTH_BITS+1 and pointers wrapping modulo DEPTH.
REQ-006 SHALL push lane i when in_valid[i]=1 and (full[i]=0, or lane i is popped in the same cycle); otherwise the word is dropped.
REQ-007 SHALL evaluate pop eligibility on pre-push state; an empty lane pushed this cycle is not popped this cycle; no bypass, so minimum in_valid-to-valid_out latency is 2 cycles.
REQ-008 SHALL pop at most one lane per cycle, and only while ENB=1; pushes continue while ENB=0.
REQ-009 In fixed mode, SHALL pop lane selector if it is non-empty, else nothing.
REQ-010 In round-robin mode, SHALL pop the first non-empty lane searching from last_grant+1 upward, wrapping modulo CHANNELS, then set last_grant to the popped lane.
REQ-011 SHALL leave last_grant unchanged in fixed mode and when no pop occurs.
REQ-012 A mode change SHALL take effect on the same cycle's grant decision.
REQ-013 On a pop, SHALL register data_out = popped word, ch_out = lane, valid_out = 1 on the next edge.
REQ-014 With no pop, SHALL drive valid_out = 0 and hold data_out and ch_out.
REQ-015 full and empty SHALL be combinational from the per-lane counts.

Reset
REQ-016 While reset_L=0, SHALL asynchronously clear all counts and pointers, set last_grant = CHANNELS-1 so lane 0 is first in round-robin order, and zero data_out, valid_out, ch_out and overflow.
REQ-017 Reset asserted mid-transfer SHALL discard all buffered words; the first edge after release behaves as a fresh start.
REQ-018 Reset values SHALL be empty = all 1s and full = all 0s.

Configuration
REQ-019 With TRANSLATER_OVF_EN defined, SHALL set overflow[i] on any dropped push to lane i, hold it until ovf_clr=1 or reset, and give a same-cycle drop priority over ovf_clr.
REQ-020 Without TRANSLATER_OVF_EN, overflow SHALL be tied to 0, ovf_clr ignored, and drop behaviour unchanged.

Verification (WIDTH=8, CH_BITS=2, DEPTH_BITS=2)
REQ-021 Push 0xA1 to lane 2 at cycle 0 with ENB=1, mode=0, selector=2 -> valid_out=1, data_out=0xA1, ch_out=2 at cycle 2.
REQ-022 Hold ENB=0, push lanes 0,1,3 with 0x10,0x11,0x13, then set ENB=1, mode=1 -> outputs lanes 0,1,3 on consecutive cycles, then valid_out=0.
REQ-023 Push 5 words 0x01..0x05 to lane 1 with ENB=0 -> full[1]=1, 0x05 dropped, overflow[1]=1 (macro on) or 0 (macro off); after ovf_clr, overflow[1]=0.
REQ-024 Lane 0 full, ENB=1, mode=0, selector=0, push 0x55 to lane 0 in the same cycle -> push accepted, overflow[0] stays 0, count stays 4.
REQ-025 Assert reset_L=0 with 3 words buffered in lane 3 -> empty[3]=1 and valid_out=0 immediately; after release, no stale output.
REQ-026 Fill all lanes 4 deep, run round-robin with ENB=1 for 16 cycles -> ch_out sequence 0,1,2,3 repeated 4 times, FIFO order preserved per lane.
